// File: rtl/wb_writeback_seq_if.sv
// Write-back bundle: request/operand capture, register-file write port and read-path forwarding.
// Latency: n/a (wiring only). Backpressure: wb_valid/wb_ready handshake owned by the slave side.
interface wb_writeback_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_done;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    modport slave (
        input  wb_valid, alu_result, mem_rdata, rt, rd, reg_dst, mem_to_reg,
        input  rs_addr, rt_addr, rf_a, rf_b,
        output wb_ready, rf_we, rf_waddr, rf_wdata, wb_done, fwd_a, fwd_b
    );

    modport master (
        output wb_valid, alu_result, mem_rdata, rt, rd, reg_dst, mem_to_reg,
        output rs_addr, rt_addr, rf_a, rf_b,
        input  wb_ready, rf_we, rf_waddr, rf_wdata, wb_done, fwd_a, fwd_b
    );
endinterface

// File: rtl/wb_writeback_seq.sv
// Register-file write-back sequencer: captures ALUOut/MDR on accept, writes the file one cycle later.
// Latency: rf_we at edge N+1, wb_done at N+2; ready only in IDLE, so one request per 3 cycles.
// Optional macro WB_BYPASS_EN forwards the pending write onto fwd_a/fwd_b during HOLD/WRITE.
module wb_writeback_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_writeback_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr_q;
    logic [ADDR_W-1:0] dest_q;
    logic              sel_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              wb_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_q      <= '0;
            mdr_q      <= '0;
            dest_q     <= '0;
            sel_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_done_q  <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.wb_valid) begin
                        alu_q   <= bus.alu_result;
                        mdr_q   <= bus.mem_rdata;
                        dest_q  <= bus.reg_dst ? bus.rd : bus.rt;
                        sel_q   <= bus.mem_to_reg;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    rf_wdata_q <= sel_q ? mdr_q : alu_q;
                    rf_waddr_q <= dest_q;
                    // $zero is hardwired, so the write is suppressed but the handshake still completes
                    rf_we_q    <= (dest_q != '0);
                    state_q    <= WRITE;
                end
                WRITE: begin
                    rf_we_q   <= 1'b0;
                    wb_done_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_ready = (state_q == IDLE);
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.wb_done  = wb_done_q;

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] pend_data;
    logic              pend_vld;

    assign pend_data = sel_q ? mdr_q : alu_q;
    assign pend_vld  = (state_q != IDLE) && (dest_q != '0);

    assign bus.fwd_a = (pend_vld && (bus.rs_addr == dest_q)) ? pend_data : bus.rf_a;
    assign bus.fwd_b = (pend_vld && (bus.rt_addr == dest_q)) ? pend_data : bus.rf_b;
`else
    logic unused_rd_addr;

    assign bus.fwd_a    = bus.rf_a;
    assign bus.fwd_b    = bus.rf_b;
    assign unused_rd_addr = &{1'b0, bus.rs_addr, bus.rt_addr};
`endif
endmodule

// File: tb/tb_wb_writeback_seq.sv
// Directed bench for wb_writeback_seq: a per-cycle vector table plus hand-written reset/bypass sequences.
module tb_wb_writeback_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_writeback_seq_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_writeback_seq #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        vld;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_dst;
        logic        m2r;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_done;
    } vec_t;

    vec_t vecs [18];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wb_valid   = 1'b0;
        bus.alu_result = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.rt         = 5'd0;
        bus.rd         = 5'd0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.rs_addr    = 5'd0;
        bus.rt_addr    = 5'd0;
        bus.rf_a       = 32'h11;
        bus.rf_b       = 32'h22;
    endtask

    task automatic req(input logic [31:0] alu, input logic [4:0] rd);
        bus.wb_valid   = 1'b1;
        bus.alu_result = alu;
        bus.mem_rdata  = 32'h0;
        bus.rd         = rd;
        bus.rt         = 5'd0;
        bus.reg_dst    = 1'b1;
        bus.mem_to_reg = 1'b0;
    endtask

    initial begin
        //        vld  alu           mem           rt     rd     rdst  m2r   rdy   we    waddr  wdata         done
        vecs[0]  = '{1'b1, 32'h0000_1234, 32'h0,        5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_AAAA, 32'hDEAD_BEEF, 5'd9,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_5555, 32'h0BAD_F00D, 5'd3,  5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0077, 32'h0000_0088, 5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0077, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0077, 1'b1};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0077, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0100, 32'h0,        5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0077, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0200, 32'h0,        5'd0,  5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0100, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0200, 32'h0,        5'd0,  5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_0100, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_0200, 32'h0,        5'd0,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h0000_0100, 1'b0};
        vecs[15] = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0200, 1'b0};
        vecs[16] = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0000_0200, 1'b1};
        vecs[17] = '{1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0000_0200, 1'b0};

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy",   {31'd0, bus.wb_ready}, 32'd1);
        chk("rst.we",    {31'd0, bus.rf_we},    32'd0);
        chk("rst.waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst.wdata", bus.rf_wdata,          32'd0);
        chk("rst.done",  {31'd0, bus.wb_done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.rdy",  {31'd0, bus.wb_ready}, 32'd1);
        chk("post_rst.we",   {31'd0, bus.rf_we},    32'd0);
        chk("post_rst.done", {31'd0, bus.wb_done},  32'd0);
        chk("post_rst.fwd_a", bus.fwd_a, 32'h11);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus.wb_valid   = vecs[i].vld;
            bus.alu_result = vecs[i].alu;
            bus.mem_rdata  = vecs[i].mem;
            bus.rt         = vecs[i].rt;
            bus.rd         = vecs[i].rd;
            bus.reg_dst    = vecs[i].reg_dst;
            bus.mem_to_reg = vecs[i].m2r;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.rdy", i),   {31'd0, bus.wb_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d.we", i),    {31'd0, bus.rf_we},    {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d.waddr", i), {27'd0, bus.rf_waddr}, {27'd0, vecs[i].e_waddr});
            chk($sformatf("v%0d.wdata", i), bus.rf_wdata,          vecs[i].e_wdata);
            chk($sformatf("v%0d.done", i),  {31'd0, bus.wb_done},  {31'd0, vecs[i].e_done});
        end

        // Forwarding of a pending write to r7 onto operand A
`ifdef WB_BYPASS_EN
        exp_pend = 32'h55;
`else
        exp_pend = 32'h11;
`endif
        @(negedge clk);
        drive_idle();
        bus.rs_addr = 5'd7;
        bus.rt_addr = 5'd3;
        req(32'h55, 5'd7);
        @(posedge clk);
        #1;
        chk("byp.hold.fwd_a", bus.fwd_a, exp_pend);
        chk("byp.hold.fwd_b", bus.fwd_b, 32'h22);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("byp.write.fwd_a", bus.fwd_a, exp_pend);
        chk("byp.write.we",    {31'd0, bus.rf_we}, 32'd1);
        chk("byp.write.waddr", {27'd0, bus.rf_waddr}, 32'd7);
        @(posedge clk);
        #1;
        chk("byp.idle.fwd_a", bus.fwd_a, 32'h11);
        chk("byp.idle.done",  {31'd0, bus.wb_done}, 32'd1);

        // Reset asserted while in HOLD: nothing is written, no completion
        @(negedge clk);
        drive_idle();
        req(32'h99, 5'd8);
        @(posedge clk);
        #1;
        chk("rhold.rdy_before", {31'd0, bus.wb_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rhold.rdy",   {31'd0, bus.wb_ready}, 32'd1);
        chk("rhold.we",    {31'd0, bus.rf_we},    32'd0);
        chk("rhold.waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rhold.wdata", bus.rf_wdata,          32'd0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rhold.c%0d.we", c),   {31'd0, bus.rf_we},    32'd0);
            chk($sformatf("rhold.c%0d.done", c), {31'd0, bus.wb_done},  32'd0);
            chk($sformatf("rhold.c%0d.rdy", c),  {31'd0, bus.wb_ready}, 32'd1);
        end

        // Reset asserted in WRITE: rf_we must drop without waiting for a clock edge
        @(negedge clk);
        req(32'hABC, 5'd10);
        @(posedge clk);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rwrite.we_before", {31'd0, bus.rf_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rwrite.we",    {31'd0, bus.rf_we},    32'd0);
        chk("rwrite.rdy",   {31'd0, bus.wb_ready}, 32'd1);
        chk("rwrite.waddr", {27'd0, bus.rf_waddr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rwrite.done", {31'd0, bus.wb_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_writeback_seq.md
Name: wb_writeback_seq

Overview:
- Write-back end of the multicycle datapath's register-file interface. The A/B operand latches read the file; this block writes it.
- Accepts one write-back request per instruction and captures the ALU result and memory read data into ALUOut/MDR holding registers.
- Selects the destination register (rt or rd) and the data source (ALU or memory), then drives the register-file write port for exactly one cycle.
- Sits between the execute/memory stages and the register-file write port, and is sequenced by the main control FSM through a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-file address width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write-back request from control.
- wb_ready  out  1  block can accept a request.
- alu_result  in  DATA_W  ALU output, sampled on accept.
- mem_rdata  in  DATA_W  memory read data, sampled on accept.
- rt  in  ADDR_W  instr[20:16].
- rd  in  ADDR_W  instr[15:11].
- reg_dst  in  1  1: destination is rd; 0: destination is rt.
- mem_to_reg  in  1  1: write mem_rdata; 0: write alu_result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- wb_done  out  1  one-cycle completion pulse.
- rs_addr  in  ADDR_W  current read address A.
- rt_addr  in  ADDR_W  current read address B.
- rf_a  in  DATA_W  register-file read data A.
- rf_b  in  DATA_W  register-file read data B.
- fwd_a  out  DATA_W  operand A toward the A/B latches.
- fwd_b  out  DATA_W  operand B toward the A/B latches.

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, alu_q=0, mdr_q=0, dest_q=0, sel_q=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0. wb_ready=1 while in reset.
- States: IDLE, HOLD, WRITE.
- wb_ready = (state==IDLE), combinational.
- Accept: wb_valid && wb_ready at edge N.
  - alu_q<=alu_result, mdr_q<=mem_rdata.
  - dest_q<=reg_dst?rd:rt, sel_q<=mem_to_reg.
  - state->HOLD.
- HOLD, edge N+1: rf_wdata<=sel_q?mdr_q:alu_q; rf_waddr<=dest_q; rf_we<=(dest_q!=0); state->WRITE.
- WRITE, edge N+2: rf_we<=0; wb_done<=1; state->IDLE. rf_waddr and rf_wdata hold their values until the next HOLD.
- wb_done is high for exactly one cycle, between edges N+2 and N+3.
- Latency: rf_we is high between edges N+1 and N+2. Earliest next accept is edge N+3; throughput is one request per 3 cycles.
- wb_valid while not ready is ignored and nothing is latched. Control must hold the request until it is accepted.
- Destination 0: rf_we stays 0 through WRITE; wb_done still pulses.
- Holding registers load only on accept. alu_result and mem_rdata changes after edge N do not affect the write.
- rst_n asserted mid-operation: state and outputs go to reset values immediately, rf_we drops asynchronously, and no wb_done pulse is issued.
- Address widths are exact and data is not extended or truncated. Both are DATA_W.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: the pending write forwards to the read path while state is HOLD or WRITE.
  - pend_data = sel_q?mdr_q:alu_q.
  - fwd_a = (rs_addr==dest_q && dest_q!=0) ? pend_data : rf_a.
  - fwd_b is the same, using rt_addr.
  - In IDLE, fwd_a=rf_a and fwd_b=rf_b.
- Undefined: fwd_a=rf_a and fwd_b=rf_b always, combinationally. The forwarding logic and comparators are absent, and the ports remain.

Test Plan:
- Reset: hold rst_n=0, then release -> all outputs 0, wb_ready=1, fwd_a==rf_a.
- ALU write: alu_result=0x0000_1234, rd=5, reg_dst=1, mem_to_reg=0, wb_valid pulsed one cycle -> rf_we=1 one cycle at edge N+1, rf_waddr=5, rf_wdata=0x1234; wb_done pulses at N+2; wb_ready=0 for 2 cycles.
- Load write: mem_rdata=0xDEAD_BEEF, rt=9, reg_dst=0, mem_to_reg=1; inputs changed to garbage after accept -> rf_waddr=9, rf_wdata=0xDEADBEEF.
- Register zero: rd=0, reg_dst=1 -> rf_we never asserts; wb_done still pulses once.
- Busy and reset: second wb_valid held from accept -> accepted only at N+3. Separately, rst_n dropped in HOLD -> rf_we stays 0, no wb_done, wb_ready=1.
- WB_BYPASS_EN: pending write to 7 with data 0x55, rs_addr=7, rf_a=0x11 -> fwd_a=0x55 during HOLD/WRITE, 0x11 in IDLE. Macro undefined -> fwd_a=0x11 throughout.
